rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Grant is registered and one-hot, with a matching 3-bit index and a valid flag in the same encoding style as the team's 8x3 priority encoder.
- The grant is held until the requester drops its request or a hold-time limit expires. Priority then rotates to the requester after the one last served.
- Sits between the request sources and the shared datapath; the shared datapath's input mux is steered by gnt_idx.

---
 rtl/rr_arbiter8.sv | 154 +++++++++++++++
 tb/tb_rr_arbiter8.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter sharing one downstream resource among
// N requesters. The grant is registered and one-hot, with a matching binary
// index and a valid flag. A grant is held until its requester drops the
// request or the hold limit expires. It is always followed by one dead cycle,
// after which priority rotates to the requester after the one last served.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         when low, no new grant is issued (a running grant continues)
//   req[N]     level-sensitive request vector, bit i = requester i
//   gnt[N]     registered one-hot grant, zero when idle
//   gnt_idx    binary index of the granted requester, zero when idle
//   gnt_valid  high while any grant bit is set
//   preempt    one-cycle pulse in the dead cycle after a timeout release

module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } state_t;

  // Last value hold_cnt reaches while a grant is visible.
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

  state_t          state;
  state_t          state_nx;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_nx;
  logic [CNTW-1:0] hold_cnt;
  logic [CNTW-1:0] hold_nx;
  logic [N-1:0]    gnt_nx;
  logic [IDXW-1:0] idx_nx;
  logic            valid_nx;
  logic            preempt_nx;

  // Rotating search
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;

  logic            req_live;
  logic            timeout;

  // Scan upward from ptr. The IDXW-bit add wraps 7->0 on its own, so this
  // needs no explicit modulo.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDXW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_live = req[gnt_idx];
  assign timeout  = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    gnt_nx     = gnt;
    idx_nx     = gnt_idx;
    valid_nx   = gnt_valid;
    preempt_nx = 1'b0;

    case (state)
      IDLE: begin
        gnt_nx   = '0;
        idx_nx   = '0;
        valid_nx = 1'b0;
        if (en && win_found) begin
          gnt_nx   = N'(1) << win_idx;
          idx_nx   = win_idx;
          valid_nx = 1'b1;
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end

      GRANT: begin
        if (!req_live || timeout) begin
          gnt_nx     = '0;
          idx_nx     = '0;
          valid_nx   = 1'b0;
          ptr_nx     = gnt_idx + 1'b1;
          // A request that falls on the timeout cycle is a normal release.
          preempt_nx = req_live && timeout;
          state_nx   = REL;
        end else begin
          // The timeout release happens before the counter could wrap.
          hold_nx = hold_cnt + 1'b1;
        end
      end

      REL: begin
        gnt_nx   = '0;
        idx_nx   = '0;
        valid_nx = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        gnt_nx   = '0;
        idx_nx   = '0;
        valid_nx = 1'b0;
        hold_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      preempt   <= preempt_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD=4). A cycle-level reference
// model tracks the current owner, how long it has held, whether a dead cycle
// is pending, and the rotation pointer. It is checked every cycle, alongside
// the directed scenarios and a randomized run.

module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  always #5 clk = ~clk;

  rr_arbiter8 #(.N(8), .IDXW(3), .MAX_HOLD(MH), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model
  int m_owner;   // -1 when nobody holds the resource
  int m_held;    // cycles the current grant has been visible
  int m_ptr;
  bit m_dead;
  bit m_pre;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_dead  = 1'b0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MH) begin
        m_pre   = req[m_owner] && (m_held == MH);
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_dead  = 1'b1;
      end else begin
        m_held++;
        m_pre = 1'b0;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
      m_pre  = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (en) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_held  = 1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    int enc;
    int ones;
    enc  = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (gnt[i]) begin
        enc = i;
        ones++;
      end
    end
    check("gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    check("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("preempt", 32'(preempt), 32'(m_pre));
    check("inv_onehot0", 32'(ones <= 1), 32'd1);
    check("inv_valid_or", 32'(gnt_valid), 32'(ones != 0));
    check("inv_idx_enc", 32'(gnt_idx), 32'(enc));
    check("inv_pre_valid", 32'(preempt && gnt_valid), 32'd0);
  endtask

  // Inputs are set between edges; the model consumes them at the posedge
  // and outputs are compared on the following negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Reset asserted between edges must clear the outputs without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int starts;
    int last;
    int expi;
    int pulses;
    bit prevv;

    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();

    // 1: single requester, release, then ptr has advanced to 1
    en = 1'b1; req = 8'h01;
    cyc();
    check("t1_gnt", 32'(gnt), 32'h01);
    check("t1_valid", 32'(gnt_valid), 32'd1);
    req = 8'h00;
    cyc();
    check("t1_rel", 32'(gnt), 32'h00);
    req = 8'hFF;
    cyc();
    cyc();
    check("t1_ptr1", 32'(gnt_idx), 32'd1);

    // 2: all requesting, timeouts rotate 0..7,0 with a 6-cycle period
    @(negedge clk);
    do_reset();
    req = 8'hFF; en = 1'b1;
    starts = 0; last = 0; expi = 0; pulses = 0; prevv = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cyc();
      if (preempt) pulses++;
      if (gnt_valid && !prevv) begin
        check("t2_order", 32'(gnt_idx), 32'(expi));
        if (starts > 0) check("t2_period", 32'(c - last), 32'd6);
        last = c;
        expi = (expi + 1) % 8;
        starts++;
      end
      prevv = gnt_valid;
    end
    check("t2_starts", 32'(starts), 32'd9);
    check("t2_preempts", 32'(pulses), 32'd8);

    // 3: after idx 5 is served, req 0010_0100 wraps around to idx 2
    do_reset();
    req = 8'h20;
    cyc();
    check("t3_g5", 32'(gnt), 32'h20);
    req = 8'h00;
    cyc();
    req = 8'h24;
    cyc();
    cyc();
    check("t3_wrap", 32'(gnt), 32'h04);

    // 4: en gates new grants only
    do_reset();
    en = 1'b0; req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_blocked", 32'(gnt), 32'h00);
    end
    en = 1'b1;
    cyc();
    check("t4_gnt", 32'(gnt), 32'h10);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("t4_hold", 32'(gnt), 32'h10);
    end
    req = 8'h00;
    cyc();
    check("t4_rel", 32'(gnt), 32'h00);
    en = 1'b1;

    // 5: other request bits toggling during a grant are ignored
    do_reset();
    req = 8'h08;
    cyc();
    for (int i = 0; i < 3; i++) begin
      req = (i % 2 == 0) ? 8'h89 : 8'h08;
      cyc();
      check("t5_gnt", 32'(gnt), 32'h08);
      check("t5_idx", 32'(gnt_idx), 32'd3);
    end

    // 6: async reset mid-grant, then ptr is back at 0
    do_reset();
    req = 8'h40;
    cyc();
    check("t6_gnt", 32'(gnt), 32'h40);
    do_reset();
    req = 8'hC0;
    cyc();
    check("t6_idx", 32'(gnt_idx), 32'd6);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 15) == 0) req = 8'h00;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
